// File: rtl/exec_pkg.sv
// exec_pkg: definitions shared by the swt16 execute stage.
//   - ALU operation codes carried on in_alu_op (3 bits)
//   - Execute-stage FSM state encoding for the iterative multiply
package exec_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_MUL = 3'd7;

  typedef enum logic {
    EXEC_IDLE = 1'b0,
    EXEC_BUSY = 1'b1
  } exec_state_e;

endpackage

// File: rtl/exec_stage_if.sv
// exec_stage_if: bundle between decode, the execute stage and the memory stage.
//   in_*      : instruction fields and control flags from decode
//   out_*     : registered fields sampled by the memory stage
//   out_stall : combinational hold request back to decode
// Modports: slave = execute stage view, master = driver/observer view.
interface exec_stage_if #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int IALU_WORD_WIDTH = 16,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4
);
  logic [2:0]                 in_alu_op;
  logic [IALU_WORD_WIDTH-1:0] in_op_a;
  logic [IALU_WORD_WIDTH-1:0] in_op_b;
  logic [DMEM_WORD_WIDTH-1:0] in_store_word;
  logic [PMEM_WORD_WIDTH-1:0] in_instr;
  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx;
  logic                       in_act_load_dmem;
  logic                       in_act_store_dmem;
  logic                       in_act_write_res_to_reg;

  logic [PMEM_WORD_WIDTH-1:0] out_instr;
  logic [IALU_WORD_WIDTH-1:0] out_res;
  logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx;
  logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr;
  logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr;
  logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word;
  logic                       out_act_load_dmem;
  logic                       out_act_store_dmem;
  logic                       out_act_write_res_to_reg;
  logic                       out_stall;

  modport slave (
    input  in_alu_op, in_op_a, in_op_b, in_store_word, in_instr, in_res_reg_idx,
           in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg,
    output out_instr, out_res, out_res_reg_idx, out_mem_rd_addr, out_mem_wr_addr,
           out_mem_wr_word, out_act_load_dmem, out_act_store_dmem,
           out_act_write_res_to_reg, out_stall
  );

  modport master (
    output in_alu_op, in_op_a, in_op_b, in_store_word, in_instr, in_res_reg_idx,
           in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg,
    input  out_instr, out_res, out_res_reg_idx, out_mem_rd_addr, out_mem_wr_addr,
           out_mem_wr_word, out_act_load_dmem, out_act_store_dmem,
           out_act_write_res_to_reg, out_stall
  );
endinterface

// File: rtl/exec_stage_iter_mul.sv
// iter_mul: iterative shift-add multiplier, one partial product per clock.
//   clock, reset : clock and asynchronous active-high reset
//   start        : load a/b, clear accumulator, begin WIDTH iterations
//   a, b         : multiplicand and multiplier
//   busy         : iterations in progress
//   last         : the upcoming edge performs the final iteration
//   product      : accumulator value after the current iteration (valid with last)
module iter_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_d, mcand_q, mplier_d, mplier_q, acc_d, acc_q, acc_step;
  logic [CNT_W-1:0] count_d, count_q;
  logic             busy_d, busy_q;

  always_comb begin
    // Only the low WIDTH product bits are kept, so the left-shifted
    // multiplicand may drop its upper bits without affecting the result.
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      count_d  = CNT_W'(WIDTH - 1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (count_q == '0) busy_d  = 1'b0;
      else               count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign last    = busy_q && (count_q == '0);
  assign product = acc_step;
endmodule

// File: rtl/exec_stage.sv
// exec_stage: execute stage of the swt16 pipeline, feeding the memory stage.
//   clock, reset : clock and asynchronous active-high reset
//   bus (slave)  : decode-side in_* fields, registered out_* fields, out_stall
// Single-cycle ALU ops, DMEM address (a+b) and store data are registered each
// edge. With macro EXEC_MUL_EN defined, op MUL with the write flag set runs an
// iterative multiply: decode is stalled and bubbles are emitted until the
// product is written. Without EXEC_MUL_EN, MUL yields 0 in one cycle.
module exec_stage
  import exec_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int IALU_WORD_WIDTH = 16,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4
) (
  input logic         clock,
  input logic         reset,
  exec_stage_if.slave bus
);
  logic [PMEM_WORD_WIDTH-1:0] instr_d, instr_q;
  logic [IALU_WORD_WIDTH-1:0] res_d, res_q;
  logic [REG_IDX_WIDTH-1:0]   idx_d, idx_q;
  logic [DMEM_ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DMEM_WORD_WIDTH-1:0] wword_d, wword_q;
  logic                       ld_d, ld_q, st_d, st_q, wr_d, wr_q;
  logic                       stall;

  function automatic logic [IALU_WORD_WIDTH-1:0] alu_calc(
    input logic [2:0]                 op,
    input logic [IALU_WORD_WIDTH-1:0] a,
    input logic [IALU_WORD_WIDTH-1:0] b
  );
    logic [IALU_WORD_WIDTH-1:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = a << b[3:0];
      ALU_SRL: r = a >> b[3:0];
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef EXEC_MUL_EN
  exec_state_e                state_d, state_q;
  logic [PMEM_WORD_WIDTH-1:0] pend_instr_d, pend_instr_q;
  logic [REG_IDX_WIDTH-1:0]   pend_idx_d, pend_idx_q;
  logic                       issue, mul_busy, mul_last;
  logic [IALU_WORD_WIDTH-1:0] mul_product;

  iter_mul #(.WIDTH(IALU_WORD_WIDTH)) u_iter_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (issue),
    .a       (bus.in_op_a),
    .b       (bus.in_op_b),
    .busy    (mul_busy),
    .last    (mul_last),
    .product (mul_product)
  );
`endif

  always_comb begin
    instr_d = bus.in_instr;
    res_d   = alu_calc(bus.in_alu_op, bus.in_op_a, bus.in_op_b);
    idx_d   = bus.in_res_reg_idx;
    addr_d  = bus.in_op_a[DMEM_ADDR_WIDTH-1:0] + bus.in_op_b[DMEM_ADDR_WIDTH-1:0];
    wword_d = bus.in_store_word;
    ld_d    = bus.in_act_load_dmem;
    st_d    = bus.in_act_store_dmem;
    wr_d    = bus.in_act_write_res_to_reg;
    stall   = 1'b0;
`ifdef EXEC_MUL_EN
    // Gating with reset keeps stall low while a held MUL sits on the inputs.
    issue        = !reset && (state_q == EXEC_IDLE) && (bus.in_alu_op == ALU_MUL) &&
                   bus.in_act_write_res_to_reg;
    state_d      = state_q;
    pend_instr_d = pend_instr_q;
    pend_idx_d   = pend_idx_q;
    // The final iteration cycle releases decode so it advances on the
    // completing edge and the multiply is not issued twice.
    stall        = issue || (mul_busy && !mul_last);
    if (issue || state_q == EXEC_BUSY) begin
      instr_d = '0;
      res_d   = '0;
      idx_d   = '0;
      addr_d  = '0;
      wword_d = '0;
      ld_d    = 1'b0;
      st_d    = 1'b0;
      wr_d    = 1'b0;
    end
    if (issue) begin
      state_d      = EXEC_BUSY;
      pend_instr_d = bus.in_instr;
      pend_idx_d   = bus.in_res_reg_idx;
    end
    if (state_q == EXEC_BUSY && mul_last) begin
      res_d   = mul_product;
      wr_d    = 1'b1;
      idx_d   = pend_idx_q;
      instr_d = pend_instr_q;
      state_d = EXEC_IDLE;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q      <= '0;
      res_q        <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      wword_q      <= '0;
      ld_q         <= 1'b0;
      st_q         <= 1'b0;
      wr_q         <= 1'b0;
`ifdef EXEC_MUL_EN
      state_q      <= EXEC_IDLE;
      pend_instr_q <= '0;
      pend_idx_q   <= '0;
`endif
    end else begin
      instr_q      <= instr_d;
      res_q        <= res_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      wword_q      <= wword_d;
      ld_q         <= ld_d;
      st_q         <= st_d;
      wr_q         <= wr_d;
`ifdef EXEC_MUL_EN
      state_q      <= state_d;
      pend_instr_q <= pend_instr_d;
      pend_idx_q   <= pend_idx_d;
`endif
    end
  end

  assign bus.out_instr                = instr_q;
  assign bus.out_res                  = res_q;
  assign bus.out_res_reg_idx          = idx_q;
  assign bus.out_mem_rd_addr          = addr_q;
  assign bus.out_mem_wr_addr          = addr_q;
  assign bus.out_mem_wr_word          = wword_q;
  assign bus.out_act_load_dmem        = ld_q;
  assign bus.out_act_store_dmem       = st_q;
  assign bus.out_act_write_res_to_reg = wr_q;
  assign bus.out_stall                = stall;
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: self-checking bench for exec_stage. Expected outputs are
// pushed to a scoreboard queue as stimulus is applied and popped one cycle
// later. Multiply scenarios follow EXEC_MUL_EN as the design does.
module tb_exec_stage;
  import exec_pkg::*;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] res;
    logic [3:0]  idx;
    logic [11:0] rd_addr;
    logic [11:0] wr_addr;
    logic [15:0] wword;
    logic        ld;
    logic        st;
    logic        wr;
  } obs_t;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];
  obs_t mask_q[$];
  obs_t m_all, m_bubble, m_mul;

  exec_stage_if #(.DMEM_ADDR_WIDTH(12), .DMEM_WORD_WIDTH(16), .IALU_WORD_WIDTH(16),
                  .PMEM_WORD_WIDTH(16), .REG_IDX_WIDTH(4)) xif ();

  exec_stage #(.DMEM_ADDR_WIDTH(12), .DMEM_WORD_WIDTH(16), .IALU_WORD_WIDTH(16),
               .PMEM_WORD_WIDTH(16), .REG_IDX_WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (xif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic obs_t observe();
    obs_t o;
    o.instr   = xif.out_instr;
    o.res     = xif.out_res;
    o.idx     = xif.out_res_reg_idx;
    o.rd_addr = xif.out_mem_rd_addr;
    o.wr_addr = xif.out_mem_wr_addr;
    o.wword   = xif.out_mem_wr_word;
    o.ld      = xif.out_act_load_dmem;
    o.st      = xif.out_act_store_dmem;
    o.wr      = xif.out_act_write_res_to_reg;
    return o;
  endfunction

  // Reference for single-cycle ops (MUL here is the single-cycle build: 0).
  function automatic obs_t model(input logic [2:0] op, input logic [15:0] a, b, sw, instr,
                                 input logic [3:0] idx, input logic ld, st, wr);
    obs_t o;
    logic [15:0] s;
    s = a + b;
    case (op)
      3'd0: o.res = a + b;
      3'd1: o.res = a - b;
      3'd2: o.res = a & b;
      3'd3: o.res = a | b;
      3'd4: o.res = a ^ b;
      3'd5: o.res = a << b[3:0];
      3'd6: o.res = a >> b[3:0];
      default: o.res = 16'h0000;
    endcase
    o.instr = instr; o.idx = idx; o.rd_addr = s[11:0]; o.wr_addr = s[11:0];
    o.wword = sw; o.ld = ld; o.st = st; o.wr = wr;
    return o;
  endfunction

  task automatic apply(input logic [2:0] op, input logic [15:0] a, b, sw, instr,
                       input logic [3:0] idx, input logic ld, st, wr);
    xif.in_alu_op = op; xif.in_op_a = a; xif.in_op_b = b; xif.in_store_word = sw;
    xif.in_instr = instr; xif.in_res_reg_idx = idx; xif.in_act_load_dmem = ld;
    xif.in_act_store_dmem = st; xif.in_act_write_res_to_reg = wr;
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    apply(ALU_ADD, 16'h1234, 16'h4321, 16'hBEEF, 16'hCAFE, 4'd9, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    o = observe();
    checks++;
    if (o !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", o); end
    checks++;
    if (xif.out_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", xif.out_stall); end
    apply(ALU_ADD, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_alu();
    logic [2:0]  ops [10] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLL, ALU_ADD, ALU_ADD};
    logic [15:0] va  [10] = '{16'hFFFF, 16'h0003, 16'hF0F0, 16'hF0F0, 16'hAAAA, 16'h0001, 16'h8000, 16'h1234, 16'h0100, 16'h0FFF};
    logic [15:0] vb  [10] = '{16'h0002, 16'h0005, 16'h3C3C, 16'h0F01, 16'hFFFF, 16'h0013, 16'h000F, 16'h0010, 16'h0023, 16'h0002};
    logic [15:0] er  [10] = '{16'h0001, 16'hFFFE, 16'h3030, 16'hFFF1, 16'h5555, 16'h0008, 16'h0001, 16'h1234, 16'h0123, 16'h1001};
    logic [11:0] ea  [10] = '{12'h001, 12'h008, 12'hD2C, 12'hFF1, 12'hAA9, 12'h014, 12'h00F, 12'h244, 12'h123, 12'h001};
    logic [2:0]  fl  [10] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b101};
    obs_t e, m, o;
    for (int i = 0; i < 10; i++) begin
      logic [15:0] sw, ins;
      sw  = (i == 8) ? 16'hBEEF : 16'(i * 16'h0111);
      ins = {4'(i), 12'hABC};
      apply(ops[i], va[i], vb[i], sw, ins, 4'(i), fl[i][2], fl[i][1], fl[i][0]);
      e.instr = ins; e.res = er[i]; e.idx = 4'(i); e.rd_addr = ea[i]; e.wr_addr = ea[i];
      e.wword = sw; e.ld = fl[i][2]; e.st = fl[i][1]; e.wr = fl[i][0];
      exp_q.push_back(e); mask_q.push_back(m_all);
      @(posedge clock); #1;
      e = exp_q.pop_front(); m = mask_q.pop_front(); o = observe();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++; $display("FAIL alu_vec%0d got=%h exp=%h", i, o & m, e & m);
      end
    end
  endtask

  task automatic test_mul(input logic [15:0] a, b, prod, input logic [3:0] idx, input string nm);
    obs_t e, m, o;
    logic [15:0] mul_ins;
    mul_ins = {4'h7, 8'h5A, idx};
    apply(ALU_MUL, a, b, 16'h1111, mul_ins, idx, 1'b0, 1'b0, 1'b1);
`ifdef EXEC_MUL_EN
    for (int k = 0; k <= 16; k++) begin
      if (k >= 1 && k <= 15)
        apply(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      else if (k == 16)
        apply(ALU_ADD, 16'h0010, 16'h0020, 16'h2222, 16'h0A0A, 4'd3, 1'b0, 1'b0, 1'b1);
      #1;
      checks++;
      if (xif.out_stall !== (k < 16)) begin
        failures++; $display("FAIL %s_stall_c%0d got=%b exp=%b", nm, k, xif.out_stall, (k < 16));
      end
      if (k < 16) begin
        e = '0; exp_q.push_back(e); mask_q.push_back(m_bubble);
      end else begin
        e = '0; e.instr = mul_ins; e.res = prod; e.idx = idx; e.wr = 1'b1;
        exp_q.push_back(e); mask_q.push_back(m_mul);
      end
      @(posedge clock); #1;
      e = exp_q.pop_front(); m = mask_q.pop_front(); o = observe();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++; $display("FAIL %s_out_e%0d got=%h exp=%h", nm, k, o & m, e & m);
      end
    end
    exp_q.push_back(model(ALU_ADD, 16'h0010, 16'h0020, 16'h2222, 16'h0A0A, 4'd3, 1'b0, 1'b0, 1'b1));
    mask_q.push_back(m_all);
`else
    #1;
    checks++;
    if (xif.out_stall !== 1'b0) begin failures++; $display("FAIL %s_stall got=%b exp=0", nm, xif.out_stall); end
    exp_q.push_back(model(ALU_MUL, a, b, 16'h1111, mul_ins, idx, 1'b0, 1'b0, 1'b1));
    mask_q.push_back(m_all);
`endif
    @(posedge clock); #1;
    e = exp_q.pop_front(); m = mask_q.pop_front(); o = observe();
    checks++;
    if ((o & m) !== (e & m)) begin
      failures++; $display("FAIL %s_next got=%h exp=%h", nm, o & m, e & m);
    end
  endtask

  task automatic test_abort();
    obs_t o;
    apply(ALU_MUL, 16'h0123, 16'h0045, 16'h0, 16'h7005, 4'd5, 1'b0, 1'b0, 1'b1);
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    o = observe();
    checks++;
    if (o !== '0) begin failures++; $display("FAIL abort_outputs got=%h exp=0", o); end
    checks++;
    if (xif.out_stall !== 1'b0) begin failures++; $display("FAIL abort_stall got=%b exp=0", xif.out_stall); end
    apply(ALU_ADD, 16'h0101, 16'h0202, 16'h0, 16'h0B0B, 4'd7, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    exp_q.push_back(model(ALU_ADD, 16'h0101, 16'h0202, 16'h0, 16'h0B0B, 4'd7, 1'b0, 1'b0, 1'b1));
    mask_q.push_back(m_all);
    @(posedge clock); #1;
    o = observe();
    checks++;
    if ((o & mask_q[0]) !== (exp_q[0] & mask_q[0])) begin
      failures++; $display("FAIL abort_then_add got=%h exp=%h", o & mask_q[0], exp_q[0] & mask_q[0]);
    end
    void'(exp_q.pop_front()); void'(mask_q.pop_front());
  endtask

  task automatic test_bubble();
    obs_t e, m, o;
    apply(ALU_MUL, 16'h0033, 16'h0044, 16'h0, 16'hF00F, 4'd2, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (xif.out_stall !== 1'b0) begin failures++; $display("FAIL bubble_stall got=%b exp=0", xif.out_stall); end
    e = '0; m = '0; m.ld = 1'b1; m.st = 1'b1; m.wr = 1'b1;
    exp_q.push_back(e); mask_q.push_back(m);
    @(posedge clock); #1;
    e = exp_q.pop_front(); m = mask_q.pop_front(); o = observe();
    checks++;
    if ((o & m) !== (e & m)) begin failures++; $display("FAIL bubble_flags got=%h exp=%h", o & m, e & m); end
    apply(ALU_SUB, 16'h0050, 16'h0051, 16'h0, 16'h1C1C, 4'd4, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(model(ALU_SUB, 16'h0050, 16'h0051, 16'h0, 16'h1C1C, 4'd4, 1'b0, 1'b0, 1'b1));
    mask_q.push_back(m_all);
    @(posedge clock); #1;
    e = exp_q.pop_front(); m = mask_q.pop_front(); o = observe();
    checks++;
    if ((o & m) !== (e & m)) begin failures++; $display("FAIL bubble_then_sub got=%h exp=%h", o & m, e & m); end
  endtask

  task automatic test_back_to_back();
    obs_t e, m, o;
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [15:0] a, b, sw, ins;
      logic [3:0]  idx;
      logic        ld, st, wr;
      op = 3'($urandom_range(0, 6));
      a = 16'($urandom); b = 16'($urandom); sw = 16'($urandom); ins = 16'($urandom);
      idx = 4'($urandom); ld = 1'($urandom); st = 1'($urandom); wr = 1'($urandom);
      apply(op, a, b, sw, ins, idx, ld, st, wr);
      exp_q.push_back(model(op, a, b, sw, ins, idx, ld, st, wr));
      mask_q.push_back(m_all);
      @(posedge clock); #1;
      e = exp_q.pop_front(); m = mask_q.pop_front(); o = observe();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++; $display("FAIL b2b_%0d op=%0d got=%h exp=%h", i, op, o & m, e & m);
      end
    end
  endtask

  initial begin
    m_all = '1;
    m_bubble = '1; m_bubble.instr = '0; m_bubble.wword = '0;
    m_mul = '0; m_mul.instr = '1; m_mul.res = '1; m_mul.idx = '1;
    m_mul.ld = 1'b1; m_mul.st = 1'b1; m_mul.wr = 1'b1;
    test_reset();
    test_alu();
    test_mul(16'h0123, 16'h0045, 16'h4E6F, 4'd5, "mul");
    test_mul(16'hFFFF, 16'hFFFF, 16'h0001, 4'd12, "mul_ovf");
    test_abort();
    test_bubble();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage of the swt16 five-stage pipeline, directly upstream of the memory stage. It registers ALU results, DMEM addresses and store data, and passes the control flags the memory stage samples. It computes single-cycle integer ALU operations and a multi-cycle iterative 16×16 multiply. During the multiply it stalls decode and emits bubbles.

## Interface
- DMEM_ADDR_WIDTH, 12, DMEM address width
- DMEM_WORD_WIDTH, 16, store data width
- IALU_WORD_WIDTH, 16, operand/result width; also the multiply iteration count
- PMEM_WORD_WIDTH, 16, instruction width
- REG_IDX_WIDTH, 4, register index width
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL
- in_op_a, in_op_b  in  IALU_WORD_WIDTH  operands from decode
- in_store_word  in  DMEM_WORD_WIDTH  store data
- in_instr  in  PMEM_WORD_WIDTH  instruction word, forwarded
- in_res_reg_idx  in  REG_IDX_WIDTH  destination register
- in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg  in  1 each  control flags; all 0 = bubble
- out_instr  out  PMEM_WORD_WIDTH  registered in_instr
- out_res  out  IALU_WORD_WIDTH  registered result
- out_res_reg_idx  out  REG_IDX_WIDTH  registered destination
- out_mem_rd_addr, out_mem_wr_addr  out  DMEM_ADDR_WIDTH  registered address
- out_mem_wr_word  out  DMEM_WORD_WIDTH  registered in_store_word
- out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg  out  1 each  registered flags
- out_stall  out  1  combinational; decode holds its outputs while high

## Operation
- **Reset.** All registered outputs are 0; FSM is IDLE; out_stall is 0.
- **ALU results.** All arithmetic is modulo 2^IALU_WORD_WIDTH.
  - ADD: a+b. SUB: a−b.
  - AND, OR, XOR: bitwise.
  - SLL: a << b[3:0], zero fill. SRL: a >> b[3:0], logical.
- **Address.** Computed as (a+b)[DMEM_ADDR_WIDTH-1:0]. The same value drives both out_mem_rd_addr and out_mem_wr_addr, for every op.
- **Issue condition.** An instruction issues as a multiply when in_alu_op==7 and in_act_write_res_to_reg==1.
- **FSM IDLE, non-multiply.** Each edge registers all outputs from the inputs.
- **FSM IDLE, multiply issued.**
  - Latch a and b into the multiplier; clear the accumulator; count=IALU_WORD_WIDTH-1.
  - Go to BUSY.
  - Outputs register a bubble: all act flags 0; res, reg_idx and addresses 0.
- **FSM BUSY.**
  - Inputs are ignored.
  - Each edge: if multiplier bit0 is 1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right.
  - If count≠0: decrement count; outputs stay a bubble.
  - If count==0:
    - out_res = low IALU_WORD_WIDTH bits of the product.
    - out_act_write_res_to_reg = 1; load/store flags = 0.
    - out_res_reg_idx and out_instr come from values latched at issue.
    - Return to IDLE.
- **Stall.** out_stall = (IDLE & multiply issue condition) | (BUSY & count≠0).
  - The issue cycle stalls, so decode holds the multiply.
  - The final BUSY cycle does not stall, so decode advances on the completing edge and the multiply is not re-issued.
- **Reset during BUSY.** Aborts the multiply: IDLE, outputs 0, stall 0, no write.
- **Bubble input (all flags 0) in IDLE.** Registers as a bubble. in_alu_op==7 with write flag 0 does not start the FSM.

## Timing
- ALU, load and store: 1-cycle latency, input to registered output.
- Multiply issued at edge E0:
  - out_stall is high in the issue cycle and in the 15 BUSY cycles with count 15..1, for IALU_WORD_WIDTH=16 stall cycles in total.
  - Result appears after edge E0+16 with the write flag set.
  - The next instruction is registered at edge E0+17.
- Outputs after E0+1 through E0+15 are bubbles.

## Configuration
- EXEC_MUL_EN defined: the multiply FSM, iterative multiplier and stall logic are present, as described above.
- EXEC_MUL_EN undefined:
  - No FSM; out_stall is tied to 0.
  - in_alu_op==7 completes in a single cycle with out_res=0; act flags pass through unchanged.

## Structure
- Shared package exec_pkg holds:
  - ALU op localparams (ALU_ADD … ALU_MUL, width 3)
  - FSM state encoding (EXEC_IDLE, EXEC_BUSY)
- One sub-module, iter_mul, holds the shift-add datapath and counter. Interface: start, a, b, busy, last, product. It is instantiated only under EXEC_MUL_EN.
- ALU mux, address adder and output registers live in exec_stage.

## Test plan
- ADD: a=0xFFFF, b=0x0002, write=1 → next cycle out_res=0x0001, out_act_write_res_to_reg=1, out_mem_rd_addr=0x001.
- Store: a=0x0100, b=0x0023, store_word=0xBEEF, store=1 → out_mem_wr_addr=0x123, out_mem_wr_word=0xBEEF, out_act_store_dmem=1, write flag 0.
- SLL a=0x0001 b=0x0013 → 0x0008. SRL a=0x8000 b=0x000F → 0x0001.
- MUL a=0x0123, b=0x0045, reg 5:
  - out_stall high for exactly 16 cycles starting with the issue cycle.
  - Bubbles on the outputs in between.
  - out_res=0x4E6F with reg_idx 5 after edge 16; next instruction accepted at edge 17.
- Overflow MUL 0xFFFF×0xFFFF → out_res=0x0001.
- Abort: reset asserted 5 cycles into a MUL → all outputs 0 and out_stall 0 immediately. After release, an ADD executes normally.
- Bubble with alu_op=7, all flags 0 → no stall, bubble out.
